// File: rtl/bus_rr_arbiter_pkg.sv
// Shared types and sizing helpers for the round-robin bus front-end arbiter.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } bus_arb_state_e;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bus_rr_arbiter_if.sv
// Host-side and bus-side handshake bundle of the round-robin arbiter.
interface bus_rr_arbiter_if #(
  parameter int unsigned NrHosts      = 2,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddressWidth = 32
);
  localparam int unsigned BeW = DataWidth / 8;

  logic [NrHosts-1:0]                   host_req_i;
  logic [NrHosts-1:0]                   host_gnt_o;
  logic [NrHosts-1:0][AddressWidth-1:0] host_addr_i;
  logic [NrHosts-1:0]                   host_we_i;
  logic [NrHosts-1:0][BeW-1:0]          host_be_i;
  logic [NrHosts-1:0][DataWidth-1:0]    host_wdata_i;
  logic [NrHosts-1:0]                   host_rvalid_o;
  logic [NrHosts-1:0][DataWidth-1:0]    host_rdata_o;
  logic [NrHosts-1:0]                   host_err_o;

  logic                    m_req_o;
  logic                    m_gnt_i;
  logic [AddressWidth-1:0] m_addr_o;
  logic                    m_we_o;
  logic [BeW-1:0]          m_be_o;
  logic [DataWidth-1:0]    m_wdata_o;
  logic                    m_rvalid_i;
  logic [DataWidth-1:0]    m_rdata_i;
  logic                    m_err_i;

  // Arbiter view.
  modport slave (
    input  host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
    output host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
    output m_req_o, m_addr_o, m_we_o, m_be_o, m_wdata_o,
    input  m_gnt_i, m_rvalid_i, m_rdata_i, m_err_i
  );

  // Environment view: the masters plus the downstream bus.
  modport master (
    output host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
    input  host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
    input  m_req_o, m_addr_o, m_we_o, m_be_o, m_wdata_o,
    output m_gnt_i, m_rvalid_i, m_rdata_i, m_err_i
  );

endinterface

// File: rtl/bus_rr_arbiter_picker.sv
// Combinational rotating-priority picker: first request at or after ptr+1, wrapping.
module bus_rr_picker #(
  parameter  int unsigned NrHosts = 2,
  localparam int unsigned SelW    = bus_arb_pkg::sel_width(NrHosts)
) (
  input  logic [NrHosts-1:0] req_i,
  input  logic [SelW-1:0]    ptr_i,
  output logic               valid_o,
  output logic [SelW-1:0]    idx_o
);

  int unsigned      cand;
  logic [SelW-1:0]  cand_idx;

  always_comb begin
    valid_o  = 1'b0;
    idx_o    = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 0; i < NrHosts; i++) begin
      cand     = (32'(ptr_i) + 32'd1 + i) % NrHosts;
      cand_idx = SelW'(cand);
      if (!valid_o && req_i[cand_idx]) begin
        valid_o = 1'b1;
        idx_o   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin front end for a single-outstanding bus host port, with a
// response watchdog that turns a silent device into an error response.
module bus_rr_arbiter
  import bus_arb_pkg::*;
#(
  parameter  int unsigned NrHosts       = 2,
  parameter  int unsigned DataWidth     = 32,
  parameter  int unsigned AddressWidth  = 32,
  parameter  int unsigned TimeoutCycles = 1024,
  localparam int unsigned SelW          = sel_width(NrHosts)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  bus_rr_arbiter_if.slave bus_if,
  output logic            busy_o,
  output logic            timeout_o,
  output logic [SelW-1:0] sel_o
);

  localparam int unsigned     CntW    = sel_width(TimeoutCycles + 1);
  localparam bit              WdogEn  = (TimeoutCycles != 0);
  localparam logic [CntW-1:0] CntLast = CntW'((TimeoutCycles == 0) ? 0 : TimeoutCycles - 1);

  bus_arb_state_e  state_q, state_d;
  logic [SelW-1:0] sel_q, sel_d;
  logic [SelW-1:0] rr_q, rr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            pick_valid;
  logic [SelW-1:0] pick_idx;

  bus_rr_picker #(
    .NrHosts(NrHosts)
  ) u_picker (
    .req_i  (bus_if.host_req_i),
    .ptr_i  (rr_q),
    .valid_o(pick_valid),
    .idx_o  (pick_idx)
  );

  // rr_q starts at the last host so host 0 wins the first arbitration.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sel_q   <= '0;
      rr_q    <= SelW'(NrHosts - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d              = state_q;
    sel_d                = sel_q;
    rr_d                 = rr_q;
    cnt_d                = cnt_q;
    timeout_o            = 1'b0;
    bus_if.host_gnt_o    = '0;
    bus_if.host_rvalid_o = '0;
    bus_if.host_rdata_o  = '0;
    bus_if.host_err_o    = '0;
    bus_if.m_req_o       = 1'b0;
    bus_if.m_addr_o      = '0;
    bus_if.m_we_o        = 1'b0;
    bus_if.m_be_o        = '0;
    bus_if.m_wdata_o     = '0;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          sel_d   = pick_idx;
          state_d = REQ;
        end
      end

      // A withdrawn request abandons the slot without moving the pointer.
      REQ: begin
        bus_if.m_req_o   = bus_if.host_req_i[sel_q];
        bus_if.m_addr_o  = bus_if.host_addr_i[sel_q];
        bus_if.m_we_o    = bus_if.host_we_i[sel_q];
        bus_if.m_be_o    = bus_if.host_be_i[sel_q];
        bus_if.m_wdata_o = bus_if.host_wdata_i[sel_q];
        if (!bus_if.host_req_i[sel_q]) begin
          state_d = IDLE;
        end else if (bus_if.m_gnt_i) begin
          bus_if.host_gnt_o[sel_q] = 1'b1;
          rr_d    = sel_q;
          cnt_d   = '0;
          state_d = WAIT;
        end
      end

      // A real response always beats a coincident watchdog expiry.
      WAIT: begin
        if (bus_if.m_rvalid_i) begin
          bus_if.host_rvalid_o[sel_q] = 1'b1;
          bus_if.host_rdata_o[sel_q]  = bus_if.m_rdata_i;
          bus_if.host_err_o[sel_q]    = bus_if.m_err_i;
          state_d = IDLE;
        end else begin
          if (cnt_q != '1) cnt_d = cnt_q + CntW'(1);
          if (WdogEn && (cnt_q == CntLast)) begin
            bus_if.host_rvalid_o[sel_q] = 1'b1;
            bus_if.host_err_o[sel_q]    = 1'b1;
            timeout_o = 1'b1;
            state_d   = DRAIN;
          end
        end
      end

      // The abandoned response is swallowed so the bus sees exactly one per grant.
      DRAIN: begin
        if (bus_if.m_rvalid_i) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q != IDLE);
  assign sel_o  = sel_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Scoreboard bench for bus_rr_arbiter: a transaction-level model predicts
// grant/response cycles and contents; a negedge monitor compares.
module tb_bus_rr_arbiter;

  localparam int unsigned NH  = 2;
  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 32;
  localparam int unsigned TO  = 4;
  localparam int unsigned BeW = DW / 8;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       busy_o;
  logic       timeout_o;
  logic [0:0] sel_o;

  bus_rr_arbiter_if #(.NrHosts(NH), .DataWidth(DW), .AddressWidth(AW)) bif();

  bus_rr_arbiter #(
    .NrHosts(NH), .DataWidth(DW), .AddressWidth(AW), .TimeoutCycles(TO)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .bus_if   (bif),
    .busy_o   (busy_o),
    .timeout_o(timeout_o),
    .sel_o    (sel_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int unsigned    cyc;
    int unsigned    host;
    logic [AW-1:0]  addr;
    logic           we;
    logic [BeW-1:0] be;
    logic [DW-1:0]  wdata;
  } gnt_exp_t;

  typedef struct {
    int unsigned   cyc;
    int unsigned   host;
    logic [DW-1:0] rdata;
    logic          err;
    logic          tmo;
  } rsp_exp_t;

  gnt_exp_t gq[$];
  rsp_exp_t rq[$];

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state: last served host and each master's pending request.
  int unsigned    last_srv = NH - 1;
  bit             pend   [NH];
  logic [AW-1:0]  p_addr [NH];
  logic           p_we   [NH];
  logic [BeW-1:0] p_be   [NH];
  logic [DW-1:0]  p_wdata[NH];

  task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic raise(input int unsigned h);
    if (!pend[h]) begin
      pend[h]    = 1'b1;
      p_addr[h]  = AW'($urandom);
      p_we[h]    = 1'($urandom);
      p_be[h]    = BeW'($urandom);
      p_wdata[h] = DW'($urandom);
      bif.host_addr_i[h]  = p_addr[h];
      bif.host_we_i[h]    = p_we[h];
      bif.host_be_i[h]    = p_be[h];
      bif.host_wdata_i[h] = p_wdata[h];
      bif.host_req_i[h]   = 1'b1;
    end
  endtask

  task automatic drop(input int unsigned h);
    pend[h] = 1'b0;
    bif.host_req_i[h] = 1'b0;
  endtask

  // Rotating priority: first pending master after the one served last.
  function automatic int unsigned model_pick();
    for (int unsigned k = 1; k <= NH; k++) begin
      int unsigned h = (last_srv + k) % NH;
      if (pend[h]) return h;
    end
    return 0;
  endfunction

  function automatic bit any_pend();
    for (int unsigned h = 0; h < NH; h++) if (pend[h]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit outs_zero();
    return (bif.host_gnt_o == '0) && (bif.host_rvalid_o == '0) && (bif.host_rdata_o == '0) &&
           (bif.host_err_o == '0) && !bif.m_req_o && (bif.m_addr_o == '0) && !bif.m_we_o &&
           (bif.m_be_o == '0) && (bif.m_wdata_o == '0) && !busy_o && !timeout_o && (sel_o == '0);
  endfunction

  // One transaction from an idle arbiter: bus grant g cycles late, device
  // response l cycles after grant; drain_add masters request while draining.
  task automatic txn(input logic [NH-1:0] add, input int unsigned g, input int unsigned l,
                     input logic [DW-1:0] rdata, input logic err, input logic [NH-1:0] drain_add);
    int unsigned w, tg;
    gnt_exp_t    ge;
    rsp_exp_t    re;
    for (int unsigned h = 0; h < NH; h++) if (add[h]) raise(h);
    w  = model_pick();
    tg = cyc + 1 + g;
    ge.cyc = tg; ge.host = w; ge.addr = p_addr[w]; ge.we = p_we[w];
    ge.be = p_be[w]; ge.wdata = p_wdata[w];
    gq.push_back(ge);
    re.cyc = (l <= TO) ? tg + l : tg + TO;
    re.host = w;
    re.rdata = (l <= TO) ? rdata : '0;
    re.err   = (l <= TO) ? err : 1'b1;
    re.tmo   = (l > TO);
    rq.push_back(re);
    step();
    repeat (g) step();
    bif.m_gnt_i = 1'b1;
    step();
    bif.m_gnt_i = 1'b0;
    drop(w);
    last_srv = w;
    for (int unsigned k = 1; k < l; k++) begin
      if (k == TO + 1)
        for (int unsigned h = 0; h < NH; h++) if (drain_add[h]) raise(h);
      step();
    end
    bif.m_rvalid_i = 1'b1;
    bif.m_rdata_i  = rdata;
    bif.m_err_i    = err;
    step();
    bif.m_rvalid_i = 1'b0;
    bif.m_rdata_i  = '0;
    bif.m_err_i    = 1'b0;
    settle();
    chk_eq("busy_after_rsp", 64'(busy_o), 64'd0);
    chk_eq("sel_hold", 64'(sel_o), 64'(w));
  endtask

  // Monitor: pops the scoreboard whenever the DUT grants or responds.
  initial forever begin
    gnt_exp_t ge;
    rsp_exp_t re;
    logic [NH-1:0][DW-1:0] exp_rd;
    @(negedge clk_i);
    while (gq.size() != 0 && gq[0].cyc < cyc) begin
      chk_eq("gnt_missing_at", 64'(cyc), 64'(gq[0].cyc));
      void'(gq.pop_front());
    end
    while (rq.size() != 0 && rq[0].cyc < cyc) begin
      chk_eq("rsp_missing_at", 64'(cyc), 64'(rq[0].cyc));
      void'(rq.pop_front());
    end
    if (bif.host_gnt_o != '0) begin
      if (gq.size() == 0) chk_eq("gnt_spurious", 64'(bif.host_gnt_o), 64'd0);
      else begin
        ge = gq.pop_front();
        chk_eq("gnt_cycle", 64'(cyc), 64'(ge.cyc));
        chk_eq("gnt_vec", 64'(bif.host_gnt_o), 64'(1) << ge.host);
        chk_eq("gnt_mreq", 64'(bif.m_req_o), 64'd1);
        chk_eq("gnt_sel", 64'(sel_o), 64'(ge.host));
        chk_eq("gnt_addr", 64'(bif.m_addr_o), 64'(ge.addr));
        chk_eq("gnt_we", 64'(bif.m_we_o), 64'(ge.we));
        chk_eq("gnt_be", 64'(bif.m_be_o), 64'(ge.be));
        chk_eq("gnt_wdata", 64'(bif.m_wdata_o), 64'(ge.wdata));
      end
    end
    if (bif.host_rvalid_o != '0) begin
      if (rq.size() == 0) chk_eq("rsp_spurious", 64'(bif.host_rvalid_o), 64'd0);
      else begin
        re = rq.pop_front();
        exp_rd = '0;
        exp_rd[re.host] = re.rdata;
        chk_eq("rsp_cycle", 64'(cyc), 64'(re.cyc));
        chk_eq("rsp_vec", 64'(bif.host_rvalid_o), 64'(1) << re.host);
        chk_eq("rsp_rdata", 64'(bif.host_rdata_o), 64'(exp_rd));
        chk_eq("rsp_err", 64'(bif.host_err_o), re.err ? (64'(1) << re.host) : 64'd0);
        chk_eq("rsp_timeout", 64'(timeout_o), 64'(re.tmo));
      end
    end else if (timeout_o) begin
      chk_eq("timeout_spurious", 64'(timeout_o), 64'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL time_limit: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    gnt_exp_t ge;
    int unsigned w;
    rst_i = 1'b1;
    bif.host_req_i = '0; bif.host_addr_i = '0; bif.host_we_i = '0;
    bif.host_be_i = '0;  bif.host_wdata_i = '0;
    bif.m_gnt_i = 1'b0;  bif.m_rvalid_i = 1'b0; bif.m_rdata_i = '0; bif.m_err_i = 1'b0;
    for (int unsigned h = 0; h < NH; h++) pend[h] = 1'b0;
    repeat (2) step();
    settle();
    chk_eq("reset_outputs", 64'(outs_zero()), 64'd1);
    step();
    rst_i = 1'b0;
    step();
    settle();
    chk_eq("post_reset_outputs", 64'(outs_zero()), 64'd1);

    // Single host read of 0x100 answered two cycles after grant.
    raise(0);
    p_addr[0] = 32'h100; p_we[0] = 1'b0;
    bif.host_addr_i[0] = 32'h100; bif.host_we_i[0] = 1'b0;
    txn('0, 0, 2, 32'hDEADBEEF, 1'b0, '0);

    // Fairness with both masters requesting continuously.
    for (int t = 0; t < 6; t++) txn(2'b11, 0, 1, DW'($urandom), 1'b0, '0);
    if (pend[0]) drop(0);
    if (pend[1]) drop(1);

    // Watchdog expiry, late response discarded, request during drain waits.
    txn(2'b01, 0, TO + 10, 32'hBAD0BAD0, 1'b0, 2'b10);
    txn('0, 0, 1, DW'($urandom), 1'b0, '0);

    // Response exactly on the expiry cycle is delivered normally.
    txn(2'b01, 0, TO, 32'h0C0FFEE0, 1'b0, '0);

    // Host1 withdraws before grant; pointer stays, host1 still wins next.
    raise(1);
    step();
    settle();
    chk_eq("wd_mreq_high", 64'(bif.m_req_o), 64'd1);
    chk_eq("wd_sel", 64'(sel_o), 64'd1);
    step();
    drop(1);
    settle();
    chk_eq("wd_mreq_drop", 64'(bif.m_req_o), 64'd0);
    step();
    settle();
    chk_eq("wd_busy_idle", 64'(busy_o), 64'd0);
    txn(2'b11, 0, 1, DW'($urandom), 1'b0, '0);

    // Reset two cycles after grant; the stale response must not surface.
    w = model_pick();
    ge.cyc = cyc + 1; ge.host = w; ge.addr = p_addr[w]; ge.we = p_we[w];
    ge.be = p_be[w]; ge.wdata = p_wdata[w];
    gq.push_back(ge);
    step();
    bif.m_gnt_i = 1'b1;
    step();
    bif.m_gnt_i = 1'b0;
    for (int unsigned h = 0; h < NH; h++) if (pend[h]) drop(h);
    step();
    rst_i = 1'b1;
    settle();
    chk_eq("mid_reset_outputs", 64'(outs_zero()), 64'd1);
    step();
    rst_i = 1'b0;
    last_srv = NH - 1;
    repeat (2) step();
    bif.m_rvalid_i = 1'b1;
    bif.m_rdata_i  = 32'h5A5A5A5A;
    step();
    bif.m_rvalid_i = 1'b0;
    bif.m_rdata_i  = '0;
    settle();
    chk_eq("post_reset_idle", 64'(outs_zero()), 64'd1);
    txn(2'b11, 0, 1, DW'($urandom), 1'b0, '0);

    // Randomized traffic: request masks, grant delays, latencies incl. timeouts.
    for (int t = 0; t < 60; t++) begin
      logic [NH-1:0] add;
      add = NH'($urandom);
      if (!any_pend()) begin
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) step();
        if (add == '0) add[$urandom_range(0, NH - 1)] = 1'b1;
      end
      txn(add, $urandom_range(0, 2), $urandom_range(1, TO + 3), DW'($urandom),
          1'($urandom), NH'($urandom));
    end
    for (int unsigned h = 0; h < NH; h++) if (pend[h]) drop(h);

    repeat (5) step();
    chk_eq("gnt_queue_empty", 64'(gq.size()), 64'd0);
    chk_eq("rsp_queue_empty", 64'(rq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
